// File: rtl/axi_stream_fork_pkg.sv
// Shared types and helpers for the stream fork and its per-branch slot.
package axi_stream_fork_pkg;

  typedef enum logic {
    FORK_REG   = 1'b0,
    FORK_COMBO = 1'b1
  } fork_mode_e;

  localparam int unsigned DEFAULT_DATA_WD = 4;

  function automatic logic hs_fire(input logic vld, input logic rdy);
    return vld && rdy;
  endfunction

endpackage

// File: rtl/axi_stream_fork_slot.sv
// One fork branch: a sticky done flag (eager, 0 cycles) or a one-entry output register (1 cycle).
// free_o tells the top this branch can let the shared input beat retire this cycle.
module axi_stream_fork_slot
  import axi_stream_fork_pkg::*;
#(
  parameter int DATA_WD = DEFAULT_DATA_WD,
  parameter int COMBO   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               offer_i,
  input  logic               go_i,
  input  logic [DATA_WD-1:0] half_data_i,
  input  logic               out_ready_i,
  output logic               out_valid_o,
  output logic [DATA_WD-1:0] out_data_o,
  output logic               free_o
);

  logic a_fire;
  assign a_fire = hs_fire(offer_i, go_i);

  if (COMBO == int'(FORK_COMBO)) begin : g_eager
    logic done_q, done_d;

    always_comb begin
      done_d = done_q;
      if (a_fire) begin
        done_d = 1'b0;
      end else if (hs_fire(out_valid_o, out_ready_i)) begin
        done_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        done_q <= 1'b0;
      end else begin
        done_q <= done_d;
      end
    end

    // Outputs are pure pass-through, so reset has to force them low without a clock.
    assign out_valid_o = rst_n && offer_i && !done_q;
    assign out_data_o  = rst_n ? half_data_i : '0;
    assign free_o      = done_q || out_ready_i;
  end else begin : g_reg
    logic               vld_q, vld_d;
    logic [DATA_WD-1:0] dat_q, dat_d;

    // A load on the same cycle as this branch's own fire wins, so a drained slot refills without a bubble.
    always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (a_fire) begin
        vld_d = 1'b1;
        dat_d = half_data_i;
      end else if (hs_fire(vld_q, out_ready_i)) begin
        vld_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end

    assign out_valid_o = vld_q;
    assign out_data_o  = dat_q;
    assign free_o      = !vld_q || out_ready_i;
  end

endmodule

// File: rtl/axi_stream_fork.sv
// Splits a double-width valid/ready beat into independent B (low half) and C (high half) streams.
// Input retires only once both halves are taken; COMBO=1 is zero latency, COMBO=0 registers each half.
module axi_stream_fork
  import axi_stream_fork_pkg::*;
#(
  parameter int DATA_WD = DEFAULT_DATA_WD,
  parameter int COMBO   = int'(FORK_REG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  input  logic [2*DATA_WD-1:0] a_data,
  output logic                 a_ready,
  output logic                 b_valid,
  output logic [DATA_WD-1:0]   b_data,
  input  logic                 b_ready,
  output logic                 c_valid,
  output logic [DATA_WD-1:0]   c_data,
  input  logic                 c_ready
);

  logic               slot_rdy [2];
  logic               slot_vld [2];
  logic [DATA_WD-1:0] slot_dat [2];
  logic               slot_free[2];

  assign slot_rdy[0] = b_ready;
  assign slot_rdy[1] = c_ready;

  for (genvar i = 0; i < 2; i++) begin : g_slot
    axi_stream_fork_slot #(
      .DATA_WD(DATA_WD),
      .COMBO  (COMBO)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .offer_i    (a_valid),
      .go_i       (a_ready),
      .half_data_i(a_data[i*DATA_WD +: DATA_WD]),
      .out_ready_i(slot_rdy[i]),
      .out_valid_o(slot_vld[i]),
      .out_data_o (slot_dat[i]),
      .free_o     (slot_free[i])
    );
  end

  assign a_ready = rst_n && slot_free[0] && slot_free[1];

  assign b_valid = slot_vld[0];
  assign b_data  = slot_dat[0];
  assign c_valid = slot_vld[1];
  assign c_data  = slot_dat[1];

endmodule

// File: tb/tb_axi_stream_fork.sv
// Bench for axi_stream_fork: index 0 is the registered fork, index 1 the eager fork.
module tb_axi_stream_fork;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         av[2];
  logic [2*W-1:0] ad[2];
  logic         br[2], cr[2];
  logic         ar[2], bv[2], cv[2];
  logic [W-1:0] bd[2], cd[2];

  axi_stream_fork #(.DATA_WD(W), .COMBO(0)) u_reg (
    .clk(clk), .rst_n(rst_n),
    .a_valid(av[0]), .a_data(ad[0]), .a_ready(ar[0]),
    .b_valid(bv[0]), .b_data(bd[0]), .b_ready(br[0]),
    .c_valid(cv[0]), .c_data(cd[0]), .c_ready(cr[0])
  );

  axi_stream_fork #(.DATA_WD(W), .COMBO(1)) u_cmb (
    .clk(clk), .rst_n(rst_n),
    .a_valid(av[1]), .a_data(ad[1]), .a_ready(ar[1]),
    .b_valid(bv[1]), .b_data(bd[1]), .b_ready(br[1]),
    .c_valid(cv[1]), .c_data(cd[1]), .c_ready(cr[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       av;
    logic [7:0] ad;
    logic       br;
    logic       cr;
    logic       ar;
    logic       bv;
    logic [3:0] bd;
    logic       cv;
    logic [3:0] cd;
  } vec_t;

  vec_t tv_reg[11];
  vec_t tv_cmb[10];

  task automatic apply_vec(input int m, input vec_t v, input string tag, input int idx);
    @(posedge clk);
    #1;
    av[m] = v.av;
    ad[m] = v.ad;
    br[m] = v.br;
    cr[m] = v.cr;
    @(negedge clk);
    chk($sformatf("%s[%0d].a_ready", tag, idx), ar[m], v.ar);
    chk($sformatf("%s[%0d].b_valid", tag, idx), bv[m], v.bv);
    chk($sformatf("%s[%0d].b_data", tag, idx), bd[m], v.bd);
    chk($sformatf("%s[%0d].c_valid", tag, idx), cv[m], v.cv);
    chk($sformatf("%s[%0d].c_data", tag, idx), cd[m], v.cd);
  endtask

  task automatic idle_inputs();
    for (int m = 0; m < 2; m++) begin
      av[m] = 1'b0;
      ad[m] = '0;
      br[m] = 1'b0;
      cr[m] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_run(input int cycles);
    int   cnt[2], nb[2], nc[2];
    logic afire[2], pbv[2], pbr[2], pcv[2], pcr[2];
    logic [W-1:0] pbd[2], pcd[2];
    for (int m = 0; m < 2; m++) begin
      cnt[m] = 0; nb[m] = 0; nc[m] = 0;
      afire[m] = 1'b0; pbv[m] = 1'b0; pbr[m] = 1'b0; pcv[m] = 1'b0; pcr[m] = 1'b0;
      pbd[m] = '0; pcd[m] = '0;
    end
    for (int cyc = 0; cyc < cycles; cyc++) begin
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
        if (!(av[m] && !afire[m])) begin
          av[m] = ($urandom_range(0, 3) != 0);
          ad[m] = cnt[m][7:0];
        end
        br[m] = ($urandom_range(0, 2) != 0);
        cr[m] = ($urandom_range(0, 2) != 0);
      end
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (pbv[m] && !pbr[m]) begin
          chk($sformatf("rnd%0d.b_hold_valid", m), bv[m], 1'b1);
          chk($sformatf("rnd%0d.b_hold_data", m), bd[m], pbd[m]);
        end
        if (pcv[m] && !pcr[m]) begin
          chk($sformatf("rnd%0d.c_hold_valid", m), cv[m], 1'b1);
          chk($sformatf("rnd%0d.c_hold_data", m), cd[m], pcd[m]);
        end
        if (bv[m] && br[m]) begin
          chk($sformatf("rnd%0d.b_seq", m), bd[m], nb[m][3:0]);
          nb[m]++;
        end
        if (cv[m] && cr[m]) begin
          chk($sformatf("rnd%0d.c_seq", m), cd[m], nc[m][7:4]);
          nc[m]++;
        end
        afire[m] = av[m] && ar[m];
        if (afire[m]) cnt[m]++;
        pbv[m] = bv[m]; pbr[m] = br[m]; pbd[m] = bd[m];
        pcv[m] = cv[m]; pcr[m] = cr[m]; pcd[m] = cd[m];
      end
    end
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rnd%0d.b_progress", m), (nb[m] >= 100), 1'b1);
      chk($sformatf("rnd%0d.c_progress", m), (nc[m] >= 100), 1'b1);
      chk($sformatf("rnd%0d.b_balance", m), ((nb[m] - cnt[m]) >= -1) && ((nb[m] - cnt[m]) <= 1), 1'b1);
      chk($sformatf("rnd%0d.c_balance", m), ((nc[m] - cnt[m]) >= -1) && ((nc[m] - cnt[m]) <= 1), 1'b1);
    end
  endtask

  initial begin
    //               av    ad     br    cr    ar    bv    bd    cv    cd
    tv_reg[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0};
    tv_reg[1]  = '{1'b1, 8'hA6, 1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 1'b1, 4'hA};
    tv_reg[2]  = '{1'b1, 8'hA7, 1'b1, 1'b1, 1'b1, 1'b1, 4'h6, 1'b1, 4'hA};
    tv_reg[3]  = '{1'b1, 8'h12, 1'b1, 1'b1, 1'b1, 1'b1, 4'h7, 1'b1, 4'hA};
    tv_reg[4]  = '{1'b1, 8'h13, 1'b0, 1'b1, 1'b0, 1'b1, 4'h2, 1'b1, 4'h1};
    tv_reg[5]  = '{1'b1, 8'h13, 1'b0, 1'b1, 1'b0, 1'b1, 4'h2, 1'b0, 4'h1};
    tv_reg[6]  = '{1'b1, 8'h13, 1'b1, 1'b0, 1'b1, 1'b1, 4'h2, 1'b0, 4'h1};
    tv_reg[7]  = '{1'b0, 8'h14, 1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 1'b1, 4'h1};
    tv_reg[8]  = '{1'b0, 8'h14, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 4'h1};
    tv_reg[9]  = '{1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 4'h1};
    tv_reg[10] = '{1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 4'h2};

    tv_cmb[0]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 4'hC, 1'b1, 4'h3};
    tv_cmb[1]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 4'hC, 1'b0, 4'h3};
    tv_cmb[2]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 4'hC, 1'b0, 4'h3};
    tv_cmb[3]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 4'hC, 1'b0, 4'h3};
    tv_cmb[4]  = '{1'b1, 8'h3D, 1'b1, 1'b1, 1'b1, 1'b1, 4'hD, 1'b1, 4'h3};
    tv_cmb[5]  = '{1'b0, 8'h3E, 1'b1, 1'b1, 1'b1, 1'b0, 4'hE, 1'b0, 4'h3};
    tv_cmb[6]  = '{1'b1, 8'h3E, 1'b1, 1'b0, 1'b0, 1'b1, 4'hE, 1'b1, 4'h3};
    tv_cmb[7]  = '{1'b1, 8'h3E, 1'b0, 1'b0, 1'b0, 1'b0, 4'hE, 1'b1, 4'h3};
    tv_cmb[8]  = '{1'b1, 8'h3E, 1'b0, 1'b1, 1'b1, 1'b0, 4'hE, 1'b1, 4'h3};
    tv_cmb[9]  = '{1'b1, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 1'b1, 4'h3};

    // Reset with a live, fully-ready producer: everything must still read zero.
    rst_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      av[m] = 1'b1; ad[m] = 8'hA5; br[m] = 1'b1; cr[m] = 1'b1;
    end
    #3;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("reset%0d.a_ready", m), ar[m], 1'b0);
      chk($sformatf("reset%0d.b_valid", m), bv[m], 1'b0);
      chk($sformatf("reset%0d.c_valid", m), cv[m], 1'b0);
      chk($sformatf("reset%0d.b_data", m), bd[m], 4'h0);
      chk($sformatf("reset%0d.c_data", m), cd[m], 4'h0);
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) apply_vec(0, tv_reg[i], "reg", i);

    // Both consumers stalled with a loaded register: nothing moves for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("reg_stall.a_ready", ar[0], 1'b0);
      chk("reg_stall.b_valid", bv[0], 1'b1);
      chk("reg_stall.b_data", bd[0], 4'h0);
      chk("reg_stall.c_data", cd[0], 4'h2);
    end

    // Mid-stall reset: outputs clear asynchronously, stalled beat is discarded.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.b_valid", bv[0], 1'b0);
    chk("mid_rst.c_valid", cv[0], 1'b0);
    chk("mid_rst.b_data", bd[0], 4'h0);
    chk("mid_rst.c_data", cd[0], 4'h0);
    chk("mid_rst.a_ready", ar[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst.b_valid", bv[0], 1'b1);
    chk("post_rst.b_data", bd[0], 4'h1);
    chk("post_rst.c_data", cd[0], 4'h2);

    for (int i = 0; i < 10; i++) apply_vec(1, tv_cmb[i], "cmb", i);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("cmb_stall.a_ready", ar[1], 1'b0);
      chk("cmb_stall.b_valid", bv[1], 1'b1);
      chk("cmb_stall.b_data", bd[1], 4'hF);
      chk("cmb_stall.c_data", cd[1], 4'h3);
    end

    do_reset();
    random_run(500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
